player_motion_ctrl: RTL

//   Parametrised 2-D successor to the single-axis player position block.

---
 rtl/player_pkg.sv | 26 ++
 rtl/player_axis_ctrl.sv | 117 +++++++++++
 rtl/player_motion_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/player_pkg.sv
// Shared encodings for the player motion block: per-axis FSM states and
// resolved button directions, plus the direction resolver used by each axis.
package player_pkg;

    typedef enum logic [1:0] {
        AXIS_IDLE   = 2'd0,
        AXIS_HOLD   = 2'd1,
        AXIS_REPEAT = 2'd2
    } axis_state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_NEG  = 2'd1,
        DIR_POS  = 2'd2
    } dir_t;

    // Opposing buttons cancel; a single pressed button gives its direction.
    function automatic dir_t resolve_dir(input logic neg, input logic pos);
        case ({neg, pos})
            2'b10:   return DIR_NEG;
            2'b01:   return DIR_POS;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/player_axis_ctrl.sv
// One motion axis: press/hold/auto-repeat FSM, hold counter and the
// step arithmetic (clamp by default, wrap-around when PLAYER_WRAP_EN is defined).
module player_axis_ctrl
    import player_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter int unsigned MAX        = 216,
    parameter int unsigned STEP       = 1,
    parameter int unsigned HOLD_TICKS = 3,
    parameter int unsigned INIT       = 0
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    input  logic         i_tick,
    input  logic         i_neg,
    input  logic         i_pos,
    output logic [W-1:0] o_pos,
    output logic         o_active
);

    localparam int unsigned CNT_W = $clog2(HOLD_TICKS + 1);

    localparam logic [W:0]       STEP_E    = (W+1)'(STEP);
    localparam logic [W:0]       MAX_E     = (W+1)'(MAX);
    localparam logic [W-1:0]     STEP_W    = W'(STEP);
    localparam logic [W-1:0]     MAX_W     = W'(MAX);
    localparam logic [W-1:0]     INIT_W    = W'(INIT);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);

`ifdef PLAYER_WRAP_EN
    localparam logic [W-1:0] UNDER_W = MAX_W;
    localparam logic [W-1:0] OVER_W  = '0;
`else
    localparam logic [W-1:0] UNDER_W = '0;
    localparam logic [W-1:0] OVER_W  = MAX_W;
`endif

    axis_state_t      r_state, w_state_nxt;
    dir_t             r_dir, w_dir_nxt, w_dir;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [W-1:0]     r_pos, w_pos_nxt;
    logic [W:0]       w_ext;
    logic [W-1:0]     w_neg_pos, w_pos_pos;
    logic             w_step;

    assign w_dir = resolve_dir(i_neg, i_pos);

    // Candidate positions; comparisons run one bit wider so pos+STEP never wraps.
    always_comb begin
        w_ext     = {1'b0, r_pos};
        w_neg_pos = (w_ext >= STEP_E)          ? (r_pos - STEP_W) : UNDER_W;
        w_pos_pos = ((w_ext + STEP_E) <= MAX_E) ? (r_pos + STEP_W) : OVER_W;
    end

    // Next-state logic: immediate step on a new press, tick-paced repeat after hold.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_step      = 1'b0;
        case (r_state)
            AXIS_IDLE: begin
                if (w_dir != DIR_NONE) begin
                    w_step      = 1'b1;
                    w_dir_nxt   = w_dir;
                    w_cnt_nxt   = '0;
                    w_state_nxt = AXIS_HOLD;
                end
            end
            default: begin
                if (w_dir == DIR_NONE) begin
                    w_dir_nxt   = DIR_NONE;
                    w_cnt_nxt   = '0;
                    w_state_nxt = AXIS_IDLE;
                end else if (w_dir != r_dir) begin
                    w_step      = 1'b1;
                    w_dir_nxt   = w_dir;
                    w_cnt_nxt   = '0;
                    w_state_nxt = AXIS_HOLD;
                end else if (i_tick) begin
                    if (r_state == AXIS_HOLD) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (r_cnt == HOLD_LAST) begin
                            w_step      = 1'b1;
                            w_state_nxt = AXIS_REPEAT;
                        end
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
        endcase
        w_pos_nxt = r_pos;
        if (w_step) begin
            w_pos_nxt = (w_dir == DIR_NEG) ? w_neg_pos : w_pos_pos;
        end
    end

    // State, latched direction, hold counter and position registers.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_state <= AXIS_IDLE;
            r_dir   <= DIR_NONE;
            r_cnt   <= '0;
            r_pos   <= INIT_W;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pos   <= w_pos_nxt;
        end
    end

    assign o_pos    = r_pos;
    assign o_active = (r_state != AXIS_IDLE);

endmodule

// File: rtl/player_motion_ctrl.sv
// Player sprite position from four direction buttons: move-tick prescaler,
// two independent axis controllers and edge flags. Wrap-around instead of
// clamping is selected by defining PLAYER_WRAP_EN.
module player_motion_ctrl
    import player_pkg::*;
#(
    parameter int unsigned X_W        = 8,
    parameter int unsigned Y_W        = 9,
    parameter int unsigned FIELD_W    = 240,
    parameter int unsigned FIELD_H    = 320,
    parameter int unsigned SPRITE_W   = 24,
    parameter int unsigned SPRITE_H   = 24,
    parameter int unsigned STEP       = 1,
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned HOLD_TICKS = 3,
    parameter int unsigned X_INIT     = 0,
    parameter int unsigned Y_INIT     = 0
) (
    input  logic           i_Clk,
    input  logic           i_Rst_n,
    input  logic           i_btn_Left,
    input  logic           i_btn_Right,
    input  logic           i_btn_Up,
    input  logic           i_btn_Down,
    output logic [X_W-1:0] o_Player_x,
    output logic [Y_W-1:0] o_Player_y,
    output logic           o_Moving,
    output logic           o_At_Edge_x,
    output logic           o_At_Edge_y
);

    localparam int unsigned X_MAX  = FIELD_W - SPRITE_W;
    localparam int unsigned Y_MAX  = FIELD_H - SPRITE_H;
    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic [X_W-1:0]    w_x;
    logic [Y_W-1:0]    w_y;
    logic              w_active_x, w_active_y;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Free-running move-tick prescaler.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    player_axis_ctrl #(
        .W          (X_W),
        .MAX        (X_MAX),
        .STEP       (STEP),
        .HOLD_TICKS (HOLD_TICKS),
        .INIT       (X_INIT)
    ) u_axis_x (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_tick   (w_tick),
        .i_neg    (i_btn_Left),
        .i_pos    (i_btn_Right),
        .o_pos    (w_x),
        .o_active (w_active_x)
    );

    player_axis_ctrl #(
        .W          (Y_W),
        .MAX        (Y_MAX),
        .STEP       (STEP),
        .HOLD_TICKS (HOLD_TICKS),
        .INIT       (Y_INIT)
    ) u_axis_y (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_tick   (w_tick),
        .i_neg    (i_btn_Up),
        .i_pos    (i_btn_Down),
        .o_pos    (w_y),
        .o_active (w_active_y)
    );

    assign o_Player_x  = w_x;
    assign o_Player_y  = w_y;
    assign o_Moving    = w_active_x | w_active_y;
    assign o_At_Edge_x = (w_x == '0) || (w_x == X_W'(X_MAX));
    assign o_At_Edge_y = (w_y == '0) || (w_y == Y_W'(Y_MAX));

endmodule
